// File: rtl/tx_arb_pkg.sv
// ============================================================================
// Module  : tx_arb_pkg
// Brief   : Shared types and constants for the serializer arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int FRAME_BITS    = 10;
    localparam int N_REQ_DEFAULT = 4;

    // Index width that stays legal (>= 1 bit) even for a single-entry range.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin picker: first set request at or after ptr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         valid_o,
    output logic [W-1:0] winner_o
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_scan;
    logic           w_found;
    logic [W:0]     w_off;
    logic [W:0]     w_sum;

    // Rotate so that bit 0 of the scan vector is the requester at ptr.
    always_comb begin
        w_dbl   = {req_i, req_i} >> ptr_i;
        w_scan  = w_dbl[N-1:0];
        w_found = 1'b0;
        w_off   = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_scan[0]) begin
                w_found = 1'b1;
                w_off   = (W+1)'(k);
            end
            w_scan = w_scan >> 1;
        end
        w_sum = {1'b0, ptr_i} + w_off;
        if (w_sum >= (W+1)'(N)) begin
            w_sum = w_sum - (W+1)'(N);
        end
        valid_o  = |req_i;
        winner_o = w_sum[W-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/tx_arbiter.sv
// ============================================================================
// Module  : tx_arbiter
// Brief   : Round-robin sharing of one edge-triggered byte serializer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_arbiter
    import tx_arb_pkg::*;
#(
    parameter int N_REQ        = N_REQ_DEFAULT,
    parameter int FRAME_CYCLES = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_i,
    input  logic [8*N_REQ-1:0]             req_data_i,
    output logic                           send_o,
    output logic [7:0]                     data_o,
    output logic [N_REQ-1:0]               ack_o,
    output logic [id_width(N_REQ)-1:0]     grant_id_o,
    output logic                           busy_o
);

    localparam int ID_W     = id_width(N_REQ);
    // A wait shorter than the frame would retrigger the serializer mid-frame.
    localparam int WAIT_LEN = (FRAME_CYCLES < FRAME_BITS) ? FRAME_BITS : FRAME_CYCLES;
    localparam int CNT_W    = id_width(WAIT_LEN);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_LEN - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               send_q, send_d;
    logic [7:0]         data_q, data_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic               busy_q, busy_d;

    logic               pick_valid;
    logic [ID_W-1:0]    pick_id;
    logic [7:0]         req_bytes [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
        assign req_bytes[i] = req_data_i[8*i +: 8];
    end

    rr_pick #(
        .N (N_REQ),
        .W (ID_W)
    ) u_pick (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .valid_o  (pick_valid),
        .winner_o (pick_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            send_q     <= 1'b0;
            data_q     <= '0;
            ack_q      <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            send_q     <= send_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_valid) state_d = ST_FIRE;
            ST_FIRE: state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == '0) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        send_d     = (state_d == ST_FIRE);
        busy_d     = (state_d != ST_IDLE);
        ack_d      = '0;
        if (state_d == ST_DONE) begin
            ack_d[grant_id_q] = 1'b1;
        end
        data_d     = data_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    data_d     = req_bytes[pick_id];
                    grant_id_d = pick_id;
                end
            end
            ST_FIRE: cnt_d = CNT_LOAD;
            ST_WAIT: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            ST_DONE: ptr_d = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
            default: ;
        endcase
    end

    assign send_o     = send_q;
    assign data_o     = data_q;
    assign ack_o      = ack_q;
    assign grant_id_o = grant_id_q;
    assign busy_o     = busy_q;

endmodule

`default_nettype wire

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
- Shares one byte-frame serializer among N_REQ requesters, round-robin.
- The serializer is edge-triggered, has no busy output and emits one 10-bit frame: start bit 1, 8 data bits LSB-first, stop bit 0, one bit per clk.
- This block selects a requester, presents its byte on data, pulses send, times the frame with its own counter and returns a per-requester ack.
- It sits between the message sources and the serializer; its send/data outputs drive the serializer inputs directly.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- FRAME_CYCLES, 10, WAIT cycles after the send pulse; minimum 10 (frame length), larger values add inter-frame gap.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- req  input  N_REQ  request per requester; held with req_data stable until ack.
- req_data  input  8*N_REQ  byte per requester; requester i uses bits [8i+7:8i].
- send  output  1  serializer trigger, high for exactly one cycle per frame.
- data  output  8  byte to serializer; stable from FIRE through DONE.
- ack  output  N_REQ  one-hot, one-cycle pulse on the served requester after the frame completes.
- grant_id  output  clog2(N_REQ)  index of the current or last winner.
- busy  output  1  high in FIRE, WAIT and DONE.

Behaviour:
- All outputs are registered. On reset: send=0, data=0, ack=0, grant_id=0, busy=0, state=IDLE, rr pointer ptr=0, counter=0.
- States: IDLE, FIRE, WAIT, DONE.
- IDLE, req==0: stay in IDLE.
- IDLE, req!=0: winner = first set bit scanning ptr, ptr+1, ..., wrapping modulo N_REQ.
  - Latch data <= req_data[winner] and grant_id <= winner.
  - Go to FIRE.
- FIRE: send=1 for this one cycle; counter <= FRAME_CYCLES-1; go to WAIT.
- WAIT: send=0; decrement counter; when counter==0, go to DONE. WAIT lasts exactly FRAME_CYCLES cycles.
- DONE: ack[grant_id]=1 for one cycle; ptr <= (grant_id+1) mod N_REQ; go to IDLE.
- Timing, with the edge ending FIRE as E:
  - Serializer samples send=1 at E.
  - Stop bit is driven at E+10.
  - With FRAME_CYCLES=10, the DONE cycle ends at edge E+11, so ack coincides with the stop bit on txd.
  - Earliest next send=1 is sampled at E+13. This satisfies the serializer rule that a new rising edge is accepted only at or after E+11.
- Fixed request-to-send latency: 1 cycle in IDLE, then send.
- Throughput: one frame per FRAME_CYCLES+3 cycles under continuous requests.
- Requester protocol: sample ack at the end of the DONE cycle and clear req at that same edge, so the next IDLE sees the request removed. A req still high in IDLE is treated as a new request at lowest priority (ptr has advanced past it).
- Simultaneous requests: exactly one winner per frame; no requester waits more than N_REQ-1 frames.
- Winner drops req mid-frame: the frame still completes and ack still pulses; a started frame is never aborted.
- req changes during FIRE/WAIT/DONE: ignored; arbitration happens only in IDLE.
- Reset mid-frame: immediate return to the reset values; no ack is issued. The serializer shares rst, so a partial frame on txd is cut.
- ptr wrap-around: N_REQ-1 wraps to 0.

Decomposition:
- Package tx_arb_pkg:
  - state enum (IDLE, FIRE, WAIT, DONE);
  - FRAME_BITS=10 constant;
  - default N_REQ;
  - function for clog2 width.
- One natural sub-module: rr_pick, a combinational round-robin picker. Inputs req and ptr; outputs valid and winner index. It is reusable by other arbiters.

Test Plan:
1. Single request: req=0001, req_data[7:0]=8'hA5 → send pulse one cycle after IDLE sample, data=A5. txd=1,1,0,1,0,0,1,0,1,0 (start, LSB-first bits, stop). ack=0001 exactly 11 cycles after send, busy high 12 cycles.
2. Simultaneous requests: req=1111, bytes 11/22/33/44, each requester clears on its ack → frames in order 11,22,33,44. Consecutive send pulses exactly 13 cycles apart; each ack one-hot and in that order.
3. Round-robin fairness: requester 0 re-asserts immediately after each ack, requester 2 holds req → service order 0,2,0,2. Requester 2 is never starved.
4. Wrap-around: ptr=3 after serving 2, req=1001 → requester 3 is served before 0, then ptr=0.
5. Reset mid-frame: rst high for 1 cycle, 4 cycles into WAIT → next cycle send=0, busy=0, ack=0, data=0, ptr=0. A pending req=0010 is then served cleanly with a full frame.
6. Winner drops req in WAIT → frame completes unchanged, ack still pulses in DONE, no second frame for that requester.
